bin_magnitude: RTL and testbench
================================

BIN_MAGNITUDE -- requirements
Module: bin_magnitude

Interface
REQ-001 SHALL have parameter FREQ_BINS, default 320, meaning number of frequency bins read per frame.
REQ-002 SHALL have parameter FREQ_W, default 20, meaning width of the signed real/imag bin values.
REQ-003 SHALL have parameter PIX_W, default 8, meaning width of the output pixel value.
REQ-004 SHALL have parameter SHIFT, default 4, meaning right shift applied to the magnitude before saturation.
REQ-005 SHALL have port clk  input  1  meaning single system clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  meaning reset, synchronous and active-low.
REQ-007 SHALL have port go  input  1  meaning one-cycle request to convert one full frame of bins.
REQ-008 SHALL have port sdft_ready  input  1  meaning transform stage idle and able to accept a read.
REQ-009 SHALL have port sdft_read  output  1  meaning one-cycle read request to the transform stage.
REQ-010 SHALL have port sdft_bin_addr  output  clog2(FREQ_BINS)  meaning bin index being read.
REQ-011 SHALL have ports bin_real and bin_imag  input  FREQ_W signed  meaning bin value returned by the transform stage.
REQ-012 SHALL have ports pix_we (1), pix_addr (clog2(FREQ_BINS)) and pix_data (PIX_W), all outputs, meaning a pixel write into the waterfall line buffer.
REQ-013 SHALL have ports busy and done, both outputs, 1 bit: busy means a frame is in progress; done is a one-cycle pulse when a frame completes.

Function
REQ-014 SHALL implement the states IDLE, REQ, ACK, MAG, WRITE and DONE.
REQ-015 SHALL move from IDLE to REQ on go, with bin index = 0, busy = 1.
REQ-016 SHALL ignore go whenever it is asserted outside IDLE (no queuing).
REQ-017 In REQ, SHALL drive sdft_read = 1 for exactly one cycle, only in a cycle where sdft_ready = 1, with sdft_bin_addr = bin index; it SHALL otherwise stay in REQ with read = 0.
REQ-018 In ACK, SHALL wait for sdft_ready = 0 and then sdft_ready = 1; on that first ready = 1 cycle it SHALL latch bin_real/bin_imag and go to MAG.
REQ-019 sdft_bin_addr SHALL hold stable from REQ until the latch in ACK.
REQ-020 In MAG (one cycle, registered), SHALL form a = |bin_real| and b = |bin_imag|; the absolute value of the most negative input SHALL saturate to 2^(FREQ_W-1)-1.
REQ-021 In MAG, SHALL compute mag = max(a,b) + (min(a,b)>>2) + (min(a,b)>>3), using FREQ_W+1 bits with no overflow.
REQ-022 In MAG, SHALL compute pix = mag >>> SHIFT, saturated to 2^PIX_W-1.
REQ-023 In WRITE, SHALL pulse pix_we for one cycle with pix_addr = bin index and pix_data = pix.
REQ-024 After WRITE, SHALL go to DONE if bin index = FREQ_BINS-1, otherwise increment the bin index and go to REQ.
REQ-025 Per-bin latency SHALL be at minimum 5 cycles (REQ 1, ACK 2, MAG 1, WRITE 1); a frame SHALL take at minimum 5*FREQ_BINS cycles.
REQ-026 DONE SHALL pulse done for one cycle, clear busy and return to IDLE; the bin index SHALL never exceed FREQ_BINS-1.
REQ-027 pix_we, sdft_read and done SHALL never be asserted in the same cycle.

Reset
REQ-028 While reset_n = 0 at a clock edge, SHALL enter IDLE and drive sdft_read = 0, sdft_bin_addr = 0, pix_we = 0, pix_addr = 0, pix_data = 0, busy = 0, done = 0, and clear the latched bins.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further pixel writes and no done pulse.
REQ-030 go sampled in the same cycle as reset_n = 0 SHALL be ignored.

Structure
REQ-031 The state encoding, the magnitude-approximation function and the saturation constants SHALL live in a shared package (bin_magnitude_pkg).
REQ-032 The registered abs/max/min/shift/saturate datapath SHALL be a single sub-module, mag_approx, instantiated once.

Verification
REQ-033 Bench SHALL drive bin_real=-100, bin_imag=40, SHIFT=0 -> expect pix_data=115.
REQ-034 Bench SHALL drive bin_real=2000, bin_imag=0, SHIFT=2 -> expect pix_data=255 (saturated from 500).
REQ-035 Bench SHALL drive bin_real=-524288, bin_imag=0, SHIFT=12 -> expect a = 524287 and pix_data=127.
REQ-036 Bench SHALL hold sdft_ready=0 for 10 cycles during REQ -> expect sdft_read to stay 0, then a single pulse once ready=1, and the address unchanged.
REQ-037 Bench SHALL pulse go with FREQ_BINS=320 and the transform stage model always ready -> expect 320 pix_we pulses at addresses 0..319 in order, done exactly once, 1600 cycles from go to done, and a second go during the frame ignored.
REQ-038 Bench SHALL assert reset_n=0 after pixel 37 -> expect busy=0, no writes and no done; a following go SHALL restart at address 0.

Source files
------------

// File: rtl/bin_magnitude_pkg.sv
// rtl/bin_magnitude_pkg.sv - shared state encoding, saturation limits and magnitude approximation
//
// Contents:
//   state_t      - frame sequencer states
//   wide_t       - working width for the magnitude datapath (supports FREQ_W up to MAX_W)
//   sat_limit    - all-ones limit of a given bit count (2^w - 1)
//   abs_sat      - absolute value of a sign-extended input, clamped to a limit
//   approx_mag   - max + min/4 + min/8 estimate of sqrt(a^2 + b^2)
package bin_magnitude_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK   = 3'd2,
        ST_MAG   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int MAX_W = 32;

    typedef logic [MAX_W:0] wide_t;

    function automatic wide_t sat_limit(input int w);
        return (wide_t'(1) << w) - wide_t'(1);
    endfunction

    // x must already be sign-extended to wide_t; the negation of the most
    // negative FREQ_W value lands one above lim and is clamped back.
    function automatic wide_t abs_sat(input wide_t x, input wide_t lim);
        wide_t m;
        m = x[MAX_W] ? (~x + wide_t'(1)) : x;
        return (m > lim) ? lim : m;
    endfunction

    // With a,b < 2^(FREQ_W-1) the result is below 1.375 * 2^(FREQ_W-1),
    // so it always fits in FREQ_W+1 bits.
    function automatic wide_t approx_mag(input wide_t a, input wide_t b);
        wide_t mx;
        wide_t mn;
        if (a >= b) begin
            mx = a;
            mn = b;
        end else begin
            mx = b;
            mn = a;
        end
        return mx + (mn >> 2) + (mn >> 3);
    endfunction

endpackage

// File: rtl/bin_magnitude_mag_approx.sv
// rtl/bin_magnitude_mag_approx.sv - registered abs/max/min/shift/saturate pixel datapath
//
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset (clears pix)
//   en            - load pix from the current re/im this cycle
//   re, im        - signed bin value
//   pix           - saturated (approx magnitude >> SHIFT)
module mag_approx
    import bin_magnitude_pkg::*;
#(
    parameter int FREQ_W = 20,
    parameter int PIX_W  = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic signed [FREQ_W-1:0] re,
    input  logic signed [FREQ_W-1:0] im,
    output logic [PIX_W-1:0]         pix
);

    localparam wide_t ABS_MAX = sat_limit(FREQ_W - 1);
    localparam wide_t PIX_MAX = sat_limit(PIX_W);

    wide_t a;
    wide_t b;
    wide_t mag;
    wide_t scaled;

    always_comb begin
        a      = abs_sat(wide_t'(re), ABS_MAX);
        b      = abs_sat(wide_t'(im), ABS_MAX);
        mag    = approx_mag(a, b);
        scaled = mag >> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix <= '0;
        end else if (en) begin
            pix <= (scaled > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : scaled[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/bin_magnitude.sv
// rtl/bin_magnitude.sv - reads a frame of transform bins and writes one pixel per bin
//
// Ports:
//   clk, reset_n           - clock, synchronous active-low reset
//   go                     - start one frame (honoured only when idle)
//   sdft_ready, sdft_read  - transform stage handshake
//   sdft_bin_addr          - bin index requested
//   bin_real, bin_imag     - bin value returned by the transform stage
//   pix_we/pix_addr/pix_data - pixel write into the line buffer
//   busy, done             - frame in progress / one-cycle completion pulse
module bin_magnitude
    import bin_magnitude_pkg::*;
#(
    parameter int FREQ_BINS = 320,
    parameter int FREQ_W    = 20,
    parameter int PIX_W     = 8,
    parameter int SHIFT     = 4,
    localparam int AW       = (FREQ_BINS > 1) ? $clog2(FREQ_BINS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     go,
    input  logic                     sdft_ready,
    output logic                     sdft_read,
    output logic [AW-1:0]            sdft_bin_addr,
    input  logic signed [FREQ_W-1:0] bin_real,
    input  logic signed [FREQ_W-1:0] bin_imag,
    output logic                     pix_we,
    output logic [AW-1:0]            pix_addr,
    output logic [PIX_W-1:0]         pix_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [AW-1:0] LAST_BIN = AW'(FREQ_BINS - 1);

    state_t                    state;
    state_t                    state_next;
    logic [AW-1:0]             bin_idx;
    logic                      seen_low;
    logic                      mag_en;
    logic signed [FREQ_W-1:0]  re_q;
    logic signed [FREQ_W-1:0]  im_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bin_idx  <= '0;
            seen_low <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_REQ:   seen_low <= 1'b0;
                // The transform stage signals a fresh result by dropping
                // ready and raising it again; only that rising cycle is valid.
                ST_ACK: begin
                    if (!sdft_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        re_q <= bin_real;
                        im_q <= bin_imag;
                    end
                end
                ST_WRITE: begin
                    if (bin_idx != LAST_BIN) begin
                        bin_idx <= bin_idx + AW'(1);
                    end
                end
                ST_DONE:  bin_idx <= '0;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        sdft_read  = 1'b0;
        pix_we     = 1'b0;
        done       = 1'b0;
        mag_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdft_ready) begin
                    sdft_read  = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (seen_low && sdft_ready) begin
                    state_next = ST_MAG;
                end
            end
            ST_MAG: begin
                mag_en     = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                pix_we     = 1'b1;
                state_next = (bin_idx == LAST_BIN) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy          = (state != ST_IDLE);
    assign sdft_bin_addr = bin_idx;
    assign pix_addr      = bin_idx;

    mag_approx #(
        .FREQ_W (FREQ_W),
        .PIX_W  (PIX_W),
        .SHIFT  (SHIFT)
    ) u_mag (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mag_en),
        .re      (re_q),
        .im      (im_q),
        .pix     (pix_data)
    );

endmodule

// File: tb/tb_bin_magnitude.sv
// tb/tb_bin_magnitude.sv - self-checking bench for bin_magnitude
module tb_bin_magnitude;

    localparam int NB = 320;
    localparam int NI = 4;
    localparam int SH [NI] = '{0, 2, 4, 12};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic go = 1'b0;
    logic sdft_ready = 1'b1;
    logic force_low = 1'b0;
    logic signed [19:0] bin_real = '0;
    logic signed [19:0] bin_imag = '0;

    logic       sdft_read     [NI];
    logic [8:0] sdft_bin_addr [NI];
    logic       pix_we        [NI];
    logic [8:0] pix_addr      [NI];
    logic [7:0] pix_data      [NI];
    logic       busy          [NI];
    logic       done          [NI];

    logic signed [19:0] re_mem [NB];
    logic signed [19:0] im_mem [NB];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bin_magnitude #(
            .FREQ_BINS (NB),
            .FREQ_W    (20),
            .PIX_W     (8),
            .SHIFT     (SH[g])
        ) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .go            (go),
            .sdft_ready    (sdft_ready),
            .sdft_read     (sdft_read[g]),
            .sdft_bin_addr (sdft_bin_addr[g]),
            .bin_real      (bin_real),
            .bin_imag      (bin_imag),
            .pix_we        (pix_we[g]),
            .pix_addr      (pix_addr[g]),
            .pix_data      (pix_data[g]),
            .busy          (busy[g]),
            .done          (done[g])
        );
    end

    // Transform stage: after an accepted read, drop ready for one cycle with
    // the requested bin on the data lines, then raise it again.
    always begin : sdft_model
        logic       acc;
        logic [8:0] acc_addr;
        @(negedge clk);
        acc      = sdft_read[0] && sdft_ready;
        acc_addr = sdft_bin_addr[0];
        @(posedge clk);
        #1;
        if (acc) begin
            sdft_ready = 1'b0;
            bin_real   = re_mem[acc_addr];
            bin_imag   = im_mem[acc_addr];
        end else begin
            sdft_ready = !force_low;
        end
    end

    function automatic int exp_pix(input int re, input int im, input int sh);
        longint a, b, mx, mn, m;
        a = (re < 0) ? -longint'(re) : longint'(re);
        b = (im < 0) ? -longint'(im) : longint'(im);
        if (a > 524287) a = 524287;
        if (b > 524287) b = 524287;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        m  = mx + mn / 4 + mn / 8;
        m  = m / (longint'(1) << sh);
        return (m > 255) ? 255 : int'(m);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string when_tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_sdft_read_%0d", when_tag, i), sdft_read[i], 0);
            chk($sformatf("%s_sdft_addr_%0d", when_tag, i), sdft_bin_addr[i], 0);
            chk($sformatf("%s_pix_we_%0d", when_tag, i), pix_we[i], 0);
            chk($sformatf("%s_pix_addr_%0d", when_tag, i), pix_addr[i], 0);
            chk($sformatf("%s_pix_data_%0d", when_tag, i), pix_data[i], 0);
            chk($sformatf("%s_busy_%0d", when_tag, i), busy[i], 0);
            chk($sformatf("%s_done_%0d", when_tag, i), done[i], 0);
        end
    endtask

    task automatic randomize_bins();
        for (int k = 3; k < NB; k++) begin
            re_mem[k] = 20'($urandom);
            im_mem[k] = 20'($urandom);
        end
    endtask

    task automatic run_frame(input int go2_at, input int stall_bin, input int abort_bin,
                             input bit timed, output bit aborted);
        int n, writes, dones, done_n, bad_addr, bad_data, overlap, extra_busy;
        int stall, stall_reads, stall_addr_bad, post, post_reads;
        n = 0; writes = 0; dones = 0; done_n = -1; bad_addr = 0; bad_data = 0;
        overlap = 0; extra_busy = 0; stall = 0; stall_reads = 0; stall_addr_bad = 0;
        post = 0; post_reads = 0; aborted = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("busy_at_start", busy[0], 1);
        while (n < 2000 && dones == 0 && !aborted) begin
            for (int i = 0; i < NI; i++) begin
                if (int'(sdft_read[i]) + int'(pix_we[i]) + int'(done[i]) > 1) overlap++;
            end
            if (post > 0) begin
                if (sdft_read[0]) begin
                    post_reads++;
                    if (sdft_bin_addr[0] != 9'(stall_bin)) stall_addr_bad++;
                end
                post--;
            end
            if (stall > 0) begin
                if (sdft_read[0]) stall_reads++;
                if (sdft_bin_addr[0] != 9'(stall_bin)) stall_addr_bad++;
                stall--;
                if (stall == 0) begin
                    force_low = 1'b0;
                    post = 4;
                end
            end
            if (pix_we[0]) begin
                for (int i = 0; i < NI; i++) begin
                    if (pix_addr[i] != 9'(writes)) bad_addr++;
                    if (writes < 3) begin
                        chk($sformatf("pix_bin%0d_sh%0d", writes, SH[i]), pix_data[i],
                            exp_pix(re_mem[writes], im_mem[writes], SH[i]));
                    end else if (int'(pix_data[i]) != exp_pix(re_mem[writes], im_mem[writes], SH[i])) begin
                        bad_data++;
                    end
                end
                if (writes == 0) chk("pix_m100_40_sh0", pix_data[0], 115);
                if (writes == 1) chk("pix_2000_0_sh2", pix_data[1], 255);
                if (writes == 2) begin
                    chk("abs_most_negative", g_dut[3].dut.u_mag.a, 524287);
                    chk("pix_most_negative_sh12", pix_data[3], 127);
                end
                if (writes == stall_bin - 1) begin
                    force_low = 1'b1;
                    stall = 10;
                end
                if (writes == abort_bin) aborted = 1'b1;
                writes++;
            end
            if (done[0]) begin
                dones++;
                done_n = n;
            end
            go = (n == go2_at);
            if (!aborted) begin
                @(negedge clk);
                n++;
            end
        end
        go = 1'b0;
        if (!aborted) begin
            repeat (10) begin
                @(negedge clk);
                if (done[0]) dones++;
                if (pix_we[0]) writes++;
                if (busy[0]) extra_busy++;
            end
            chk("frame_writes", writes, NB);
            chk("frame_dones", dones, 1);
            chk("idle_after_frame", extra_busy, 0);
            if (timed) chk("go_to_done_cycles", done_n, 5 * NB);
        end
        chk("pix_addr_order", bad_addr, 0);
        chk("pix_data_random", bad_data, 0);
        chk("exclusive_strobes", overlap, 0);
        if (stall_bin >= 0) begin
            chk("stall_no_read", stall_reads, 0);
            chk("stall_addr_stable", stall_addr_bad, 0);
            chk("stall_single_read", post_reads, 1);
        end
    endtask

    initial begin
        bit ab;
        int w, d, b;
        re_mem[0] = -20'sd100;  im_mem[0] = 20'sd40;
        re_mem[1] = 20'sd2000;  im_mem[1] = 20'sd0;
        re_mem[2] = 20'h80000;  im_mem[2] = 20'sd0;
        randomize_bins();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Frame with a ready stall in front of bin 1 and a go mid-frame.
        run_frame(200, 1, -1, 1'b0, ab);

        // Abort after pixel 37, with go raised during the reset cycle.
        run_frame(-1, -1, 37, 1'b0, ab);
        chk("abort_reached", ab, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy_cleared", busy[0], 0);
        go = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        go = 1'b0;
        check_reset_outputs("after_abort");
        w = 0; d = 0; b = 0;
        repeat (20) begin
            @(negedge clk);
            if (pix_we[0]) w++;
            if (done[0]) d++;
            if (busy[0]) b++;
        end
        chk("abort_no_writes", w, 0);
        chk("abort_no_done", d, 0);
        chk("abort_stays_idle", b, 0);

        // Fresh data, unstalled timed frame restarting at address 0.
        randomize_bins();
        run_frame(777, -1, -1, 1'b1, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
